// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle of the branch resolve queue: record, resolve,
// predictor renew, flush redirect and status signals.
interface branch_resolve_queue_if #(
    parameter int LOW_ADDR_WIDTH = 8,
    parameter int PC_WIDTH       = 32,
    parameter int PTR_WIDTH      = 2,
    parameter int CNT_WIDTH      = 16
);
    logic                      record_valid;
    logic [LOW_ADDR_WIDTH-1:0] record_addr;
    logic                      record_pred;
    logic [PC_WIDTH-1:0]       record_fallthrough;
    logic                      record_ready;

    logic                      resolve_valid;
    logic                      resolve_taken;
    logic [PC_WIDTH-1:0]       resolve_target;

    logic                      renew_valid;
    logic [LOW_ADDR_WIDTH-1:0] renew_addr;
    logic                      renew_result;

    logic                      flush_valid;
    logic [PC_WIDTH-1:0]       flush_pc;

    logic                      resolve_error;
    logic [CNT_WIDTH-1:0]      mispredict_count;
    logic [PTR_WIDTH:0]        occupancy;

    // Pipeline side: fetch records, execute resolves, both observe the results.
    modport master (
        output record_valid, record_addr, record_pred, record_fallthrough,
        input  record_ready,
        output resolve_valid, resolve_taken, resolve_target,
        input  renew_valid, renew_addr, renew_result,
        input  flush_valid, flush_pc,
        input  resolve_error, mispredict_count, occupancy
    );

    modport slave (
        input  record_valid, record_addr, record_pred, record_fallthrough,
        output record_ready,
        input  resolve_valid, resolve_taken, resolve_target,
        output renew_valid, renew_addr, renew_result,
        output flush_valid, flush_pc,
        output resolve_error, mispredict_count, occupancy
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolving the head renews the predictor
// and, on mispredict, flushes the queue. Outputs registered, 1-cycle latency; pushes dropped when full.
module branch_resolve_queue #(
    parameter int LOW_ADDR_WIDTH = 8,
    parameter int PC_WIDTH       = 32,
    parameter int DEPTH          = 4,
    parameter int PTR_WIDTH      = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_resolve_queue_if.slave   bus
);
    typedef struct packed {
        logic [LOW_ADDR_WIDTH-1:0] addr;
        logic                      pred;
        logic [PC_WIDTH-1:0]       fallthrough;
    } entry_t;

    localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH+1)'(DEPTH);

    entry_t               mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH:0]   count;
    logic [PTR_WIDTH:0]   count_nxt;

    entry_t head;
    logic   pop;
    logic   push;
    logic   mispredict;

    assign head       = mem[rd_ptr];
    assign pop        = bus.resolve_valid && (count != '0);
    assign mispredict = pop && (head.pred != bus.resolve_taken);
    // Readiness comes from the registered count, so a pop this cycle never frees a slot early.
    assign push       = bus.record_valid && bus.record_ready && !mispredict;

    assign bus.record_ready = (count != FULL);
    assign bus.occupancy    = count;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: bus.record_addr, pred: bus.record_pred,
                             fallthrough: bus.record_fallthrough};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            // Everything younger than the mispredicted branch is wrong-path.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.renew_valid      <= 1'b0;
            bus.renew_addr       <= '0;
            bus.renew_result     <= 1'b0;
            bus.flush_valid      <= 1'b0;
            bus.flush_pc         <= '0;
            bus.resolve_error    <= 1'b0;
            bus.mispredict_count <= '0;
        end else begin
            bus.renew_valid   <= pop;
            bus.flush_valid   <= mispredict;
            bus.resolve_error <= bus.resolve_valid && (count == '0);
            if (pop) begin
                bus.renew_addr   <= head.addr;
                bus.renew_result <= bus.resolve_taken;
            end
            if (mispredict) begin
                bus.flush_pc <= bus.resolve_taken ? bus.resolve_target : head.fallthrough;
                if (bus.mispredict_count != '1) begin
                    bus.mispredict_count <= bus.mispredict_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed plus random stimulus against a queue-based reference model of the
// branch resolve queue.
module tb_branch_resolve_queue;
    localparam int AW    = 8;
    localparam int PW    = 32;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;
    localparam int CW    = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          pred;
        logic [PW-1:0] ft;
    } ent_t;

    logic clk;
    logic rst_n;

    branch_resolve_queue_if #(.LOW_ADDR_WIDTH(AW), .PC_WIDTH(PW), .PTR_WIDTH(PTRW),
                              .CNT_WIDTH(CW)) bus ();

    branch_resolve_queue #(.LOW_ADDR_WIDTH(AW), .PC_WIDTH(PW), .DEPTH(DEPTH),
                           .PTR_WIDTH(PTRW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    ent_t          q[$];
    logic          m_renew_valid;
    logic [AW-1:0] m_renew_addr;
    logic          m_renew_result;
    logic          m_flush_valid;
    logic [PW-1:0] m_flush_pc;
    logic          m_err;
    int            m_mis_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_renew_valid  = 1'b0;
        m_renew_addr   = '0;
        m_renew_result = 1'b0;
        m_flush_valid  = 1'b0;
        m_flush_pc     = '0;
        m_err          = 1'b0;
        m_mis_cnt      = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".renew_valid"},  32'(bus.renew_valid),      32'(m_renew_valid));
        check({tag, ".renew_addr"},   32'(bus.renew_addr),       32'(m_renew_addr));
        check({tag, ".renew_result"}, 32'(bus.renew_result),     32'(m_renew_result));
        check({tag, ".flush_valid"},  32'(bus.flush_valid),      32'(m_flush_valid));
        check({tag, ".flush_pc"},     bus.flush_pc,              m_flush_pc);
        check({tag, ".resolve_error"},32'(bus.resolve_error),    32'(m_err));
        check({tag, ".mis_count"},    32'(bus.mispredict_count), 32'(m_mis_cnt));
        check({tag, ".occupancy"},    32'(bus.occupancy),        32'(q.size()));
        check({tag, ".record_ready"}, 32'(bus.record_ready),     32'(q.size() < DEPTH));
    endtask

    // One clock: drive inputs, advance the model by the queue rules, compare after the edge.
    task automatic step(input string tag, input bit rv, input logic [AW-1:0] a, input bit p,
                        input logic [PW-1:0] ft, input bit sv, input bit tk,
                        input logic [PW-1:0] tg);
        bit   ready;
        bit   mis;
        ent_t h;
        @(negedge clk);
        bus.record_valid       = rv;
        bus.record_addr        = a;
        bus.record_pred        = p;
        bus.record_fallthrough = ft;
        bus.resolve_valid      = sv;
        bus.resolve_taken      = tk;
        bus.resolve_target     = tg;
        ready         = q.size() < DEPTH;
        mis           = 1'b0;
        m_renew_valid = 1'b0;
        m_flush_valid = 1'b0;
        m_err         = sv && (q.size() == 0);
        if (sv && q.size() > 0) begin
            h = q.pop_front();
            m_renew_valid  = 1'b1;
            m_renew_addr   = h.addr;
            m_renew_result = tk;
            if (h.pred != tk) begin
                mis           = 1'b1;
                m_flush_valid = 1'b1;
                m_flush_pc    = tk ? tg : h.ft;
                if (m_mis_cnt < (1 << CW) - 1) m_mis_cnt++;
                q.delete();
            end
        end
        if (rv && ready && !mis) q.push_back('{addr: a, pred: p, ft: ft});
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic push(input string tag, input logic [AW-1:0] a, input bit p, input logic [PW-1:0] ft);
        step(tag, 1'b1, a, p, ft, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input string tag, input bit tk, input logic [PW-1:0] tg);
        step(tag, 1'b0, '0, 1'b0, '0, 1'b1, tk, tg);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst_n                  = 1'b0;
        bus.record_valid       = 1'b0;
        bus.record_addr        = '0;
        bus.record_pred        = 1'b0;
        bus.record_fallthrough = '0;
        bus.resolve_valid      = 1'b0;
        bus.resolve_taken      = 1'b0;
        bus.resolve_target     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Correct taken prediction: renew only.
        push("t1.push", 8'h12, 1'b1, 32'h104);
        resolve("t1.res", 1'b1, 32'h200);

        // Predicted not-taken, actually taken: flush to target.
        push("t2.push", 8'h05, 1'b0, 32'h40);
        resolve("t2.res", 1'b1, 32'h80);

        // Head predicted taken but falls through; younger entries and same-cycle push discarded.
        push("t3.p0", 8'h21, 1'b1, 32'h30);
        push("t3.p1", 8'h22, 1'b0, 32'h50);
        push("t3.p2", 8'h23, 1'b1, 32'h60);
        step("t3.res", 1'b1, 8'h24, 1'b0, 32'h70, 1'b1, 1'b0, 32'h999);
        resolve("t3.err0", 1'b1, 32'h0);
        resolve("t3.err1", 1'b0, 32'h0);
        idle("t3.idle");

        // Fill, overflow push dropped, drain in order.
        for (int i = 1; i <= 5; i++) push("t4.push", 8'(i), 1'(i & 1), 32'(i * 16));
        for (int i = 1; i <= 4; i++) resolve("t4.res", 1'(i & 1), 32'h1000);
        idle("t4.idle");

        // Steady push + correct resolve; pointers wrap, occupancy constant.
        push("t5.pre0", 8'h40, 1'b0, 32'h400);
        push("t5.pre1", 8'h41, 1'b1, 32'h410);
        for (int i = 0; i < 10; i++) begin
            step("t5.steady", 1'b1, 8'(8'h42 + i), 1'(i & 1), 32'(32'h420 + i),
                 1'b1, q.size() > 0 ? q[0].pred : 1'b0, 32'h2000);
        end
        while (q.size() > 0) resolve("t5.drain", q[0].pred, 32'h0);

        // Full queue rejects a push even with a concurrent pop.
        for (int i = 0; i < 4; i++) push("t6.fill", 8'(8'h60 + i), 1'b1, 32'h600);
        step("t6.fullpop", 1'b1, 8'h6f, 1'b1, 32'h6f0, 1'b1, 1'b1, 32'h0);
        while (q.size() > 0) resolve("t6.drain", 1'b1, 32'h0);

        // Random traffic; resolves mostly agree with the prediction.
        for (int i = 0; i < 400; i++) begin
            bit sv;
            bit tk;
            sv = ($urandom_range(0, 2) != 0);
            tk = (q.size() > 0 && $urandom_range(0, 7) != 0) ? q[0].pred : 1'($urandom);
            step("rand", 1'($urandom), 8'($urandom), 1'($urandom), $urandom, sv, tk, $urandom);
        end

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++) push("t7.push", 8'(8'h70 + i), 1'b0, 32'h700);
        @(negedge clk);
        bus.record_valid  = 1'b0;
        bus.resolve_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t7.rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle("t7.after0");
        idle("t7.after1");
        resolve("t7.err", 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of outstanding branch predictions between the fetch-stage predictor and the execute stage.
- Fetch records each predicted branch: low PC index, predicted direction and fall-through PC.
- When execute resolves the oldest branch, the block does three things: drives the predictor's renew interface (renew_valid/renew_addr/renew_result), detects a misprediction, and issues a pipeline flush with the corrected PC.
- It is the update/writer side of the global branch predictor's renew port.

Parameters:
- LOW_ADDR_WIDTH, 8, width of the predictor table index carried per entry.
- PC_WIDTH, 32, width of fall-through, target and flush PCs.
- DEPTH, 4, queue entries; must be a power of two and at least 2.
- PTR_WIDTH, 2, log2(DEPTH).
- CNT_WIDTH, 16, width of the misprediction counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- record_valid  input  1  fetch pushes a predicted branch this cycle.
- record_addr  input  LOW_ADDR_WIDTH  predictor index of the branch.
- record_pred  input  1  predicted direction (1 = taken).
- record_fallthrough  input  PC_WIDTH  PC of the next sequential instruction.
- record_ready  output  1  queue not full; combinational from the registered count.
- resolve_valid  input  1  execute resolves the oldest outstanding branch.
- resolve_taken  input  1  actual direction.
- resolve_target  input  PC_WIDTH  actual taken target.
- renew_valid  output  1  predictor update strobe.
- renew_addr  output  LOW_ADDR_WIDTH  predictor index to update.
- renew_result  output  1  actual direction for the update.
- flush_valid  output  1  misprediction redirect strobe.
- flush_pc  output  PC_WIDTH  corrected fetch PC.
- resolve_error  output  1  one-cycle pulse: resolve arrived while the queue was empty.
- mispredict_count  output  CNT_WIDTH  saturating count of mispredictions.
- occupancy  output  PTR_WIDTH+1  current entry count.

Behaviour:
Reset:
- Pointers and count are 0; record_ready = 1.
- renew_valid, renew_addr, renew_result, flush_valid, flush_pc, resolve_error and mispredict_count are all 0.
- Reset asserted mid-operation discards every entry immediately; no renew or flush is emitted for the discarded entries.

Storage:
- Circular buffer with write pointer, read pointer and a count of width PTR_WIDTH+1.
- Pointers wrap modulo DEPTH.

Push:
- Accepted when record_valid && record_ready && no flush is being generated this cycle.
- A push while full (record_ready = 0) is dropped; fetch must hold or stall.
- record_ready reflects the count before this edge. A full queue rejects a push even if a pop happens in the same cycle.

Resolve:
- When resolve_valid and count > 0, the head entry is popped at this edge.
- Next cycle (1-cycle latency, registered, single-cycle pulse):
  - renew_valid = 1, renew_addr = head.addr, renew_result = resolve_taken.
- Misprediction is head.pred != resolve_taken. On misprediction, in the same cycle as the renew pulse:
  - flush_valid = 1.
  - flush_pc = resolve_target if resolve_taken, otherwise head.fallthrough.
  - mispredict_count increments and saturates at all-ones.
- A resolve when count == 0 produces no pop and no renew; it pulses resolve_error next cycle.

Flush:
- The edge that captures a misprediction also clears the whole queue: pointers and count return to 0, and every younger entry is discarded.
- A push presented in that same cycle is dropped.
- Wrong-path branches are never renewed.

Simultaneous push and correct resolve (count not full):
- Both take effect; count is unchanged; pointers advance independently.

Outputs:
- renew_valid and flush_valid are low in every cycle not described above.
- renew_addr, renew_result and flush_pc hold their last values while the strobes are low.
- occupancy = count.

Test Plan:
- Reset, then push addr=0x12 pred=1 fallthrough=0x104; resolve taken=1 target=0x200 -> next cycle renew_valid=1, renew_addr=0x12, renew_result=1, flush_valid=0, mispredict_count=0, occupancy=0.
- Push addr=0x05 pred=0 fallthrough=0x40; resolve taken=1 target=0x80 -> renew_result=1, flush_valid=1, flush_pc=0x80, mispredict_count=1.
- Push 3 entries, the head predicted taken with fallthrough 0x30; resolve taken=0 -> flush_pc=0x30, occupancy=0 next cycle, and a push presented in the resolve cycle is dropped; the next 2 resolves give resolve_error pulses and no renew.
- Push 4 entries (addrs 1,2,3,4) -> record_ready=0; 5th push dropped; 4 correct resolves -> renews in order 1,2,3,4, then record_ready=1.
- Steady push plus correct resolve every cycle for 10 cycles with DEPTH=4 -> pointers wrap, occupancy constant, renew_addr sequence matches push order.
- Assert rst_n low with 3 entries queued -> occupancy=0 and record_ready=1 immediately; no renew or flush after release.
